// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the IF/MEM unified-memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned MEM_LAT_DEF = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter with a zero flag, used to time the memory read
// latency. It saturates at zero when decremented there.
module mem_lat_counter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = MEM_LAT_DEF,
  parameter int unsigned CW      = $clog2(MEM_LAT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: load has priority over decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register, cleared by the asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter and sequencer for a single-ported memory shared by the IF and MEM
// pipeline stages. One access at a time: IDLE -> ISSUE -> WAIT -> DONE.
// Optional macro ARB_RR_EN selects round-robin arbitration; otherwise DM has
// fixed priority over IF.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned INST_W  = 32,
  parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [INST_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

  arb_state_t        state_q,    state_d;
  grant_t            grant_q,    grant_d;
  logic              we_q,       we_d;
  logic              sel_hi_q,   sel_hi_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [DATA_W-1:0] wdata_q,    wdata_d;
  logic [INST_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic pick_dm;
  logic cnt_zero;
  logic unused_addr_bits;

  assign unused_addr_bits = ^{if_addr[1:0], dm_addr[2:0]};

  mem_lat_counter #(
    .MEM_LAT (MEM_LAT),
    .CW      (CNT_W)
  ) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (state_q == ISSUE),
    .dec      (state_q == WAIT),
    .load_val (CNT_W'(MEM_LAT - 1)),
    .zero     (cnt_zero)
  );

  // Arbitration decision, only consumed in IDLE.
  always_comb begin
`ifdef ARB_RR_EN
    // grant_q holds the last granted requester and serves as the RR flag.
    pick_dm = dm_req && (!if_req || (grant_q == GNT_IF));
`else
    pick_dm = dm_req;
`endif
  end

  // FSM next state, request latching and read data capture.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    we_d       = we_q;
    sel_hi_d   = sel_hi_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          state_d = ISSUE;
          if (pick_dm) begin
            grant_d  = GNT_DM;
            we_d     = dm_we;
            sel_hi_d = 1'b0;
            addr_d   = {dm_addr[ADDR_W-1:3], 3'b000};
            wdata_d  = dm_wdata;
          end else begin
            grant_d  = GNT_IF;
            we_d     = 1'b0;
            sel_hi_d = if_addr[2];
            addr_d   = {if_addr[ADDR_W-1:3], 3'b000};
            wdata_d  = '0;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_zero) begin
          state_d = DONE;
          if (grant_q == GNT_IF) begin
            if_rdata_d = sel_hi_q ? mem_rdata[DATA_W-1:INST_W] : mem_rdata[INST_W-1:0];
          end else if (!we_q) begin
            dm_rdata_d = mem_rdata;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_q    <= GNT_IF;
      we_q       <= 1'b0;
      sel_hi_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      we_q       <= we_d;
      sel_hi_q   <= sel_hi_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = (state_q == ISSUE) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_ack    = (state_q == DONE) && (grant_q == GNT_IF);
  assign dm_ack    = (state_q == DONE) && (grant_q == GNT_DM);
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign busy      = (state_q != IDLE);
  assign stall_if  = if_req && !if_ack;
  assign stall_mem = dm_req && !dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural memory and a
// transaction-level reference model (grant order, ack timing, data).
module tb_mem_port_arbiter;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [63:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [63:0] dm_addr = '0;
  logic [63:0] dm_wdata = '0;
  logic        dm_ack;
  logic [63:0] dm_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;
  logic        busy;

  int checks = 0;
  int errors = 0;

  bit          last_dm = 1'b0;
  logic [31:0] m_if_rdata = '0;
  logic [63:0] m_dm_rdata = '0;

  logic [63:0] dev_mem [logic [63:0]];
  logic [63:0] ref_mem [logic [63:0]];
  logic [63:0] dly [L];

  mem_port_arbiter #(
    .ADDR_W  (64),
    .DATA_W  (64),
    .INST_W  (32),
    .MEM_LAT (L)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_ack    (dm_ack),
    .dm_rdata  (dm_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] seed_word(input logic [63:0] a);
    return {a[31:0] ^ 32'hC3A5_0F1E, ~a[31:0] + 32'h0000_1234};
  endfunction

  function automatic logic [63:0] al(input logic [63:0] a);
    return {a[63:3], 3'b000};
  endfunction

  function automatic logic [63:0] dev_rd(input logic [63:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : seed_word(a);
  endfunction

  function automatic logic [63:0] ref_rd(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : seed_word(a);
  endfunction

  // Memory device: read data appears L cycles after the strobe cycle,
  // garbage otherwise so a mistimed capture is visible.
  always @(posedge clk) begin
    for (int i = L - 1; i > 0; i--) dly[i] <= dly[i-1];
    dly[0] <= (mem_en && !mem_we) ? dev_rd(mem_addr) : {$urandom, $urandom};
    if (mem_en && mem_we) dev_mem[mem_addr] = mem_wdata;
  end
  assign mem_rdata = dly[L-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dm_model(input bit we, input logic [63:0] a, input logic [63:0] wd,
                          output logic [63:0] exp);
    if (we) begin
      ref_mem[al(a)] = wd;
      exp = m_dm_rdata;
    end else begin
      exp = ref_rd(al(a));
    end
  endtask

  // One or two requests raised together from IDLE; checks every cycle until
  // the DUT is back in IDLE.
  task automatic txn(input bit do_if, input logic [63:0] ia, input bit do_dm,
                     input bit dwe, input logic [63:0] da, input logic [63:0] dwd);
    bit          dm_first;
    int          g_if, g_dm, a_if, a_dm, last_e;
    bit          e_en, e_ack_if, e_ack_dm, e_busy;
    logic [63:0] w;
    logic [31:0] exp_if;
    logic [63:0] exp_dm;
    exp_if = m_if_rdata;
    exp_dm = m_dm_rdata;
`ifdef ARB_RR_EN
    dm_first = do_dm && (!do_if || !last_dm);
`else
    dm_first = do_dm;
`endif
    g_dm = (do_if && !dm_first) ? L + 3 : 0;
    g_if = dm_first ? L + 3 : 0;
    a_if = g_if + L + 1;
    a_dm = g_dm + L + 1;
    if (do_dm && dm_first) dm_model(dwe, da, dwd, exp_dm);
    if (do_if) begin
      w = ref_rd(al(ia));
      exp_if = ia[2] ? w[63:32] : w[31:0];
    end
    if (do_dm && !dm_first) dm_model(dwe, da, dwd, exp_dm);
    if (do_if && do_dm) last_dm = !dm_first;
    else if (do_if || do_dm) last_dm = do_dm;
    last_e = ((do_if && do_dm) ? L + 3 : 0) + L + 2;

    if_req   = do_if;
    if_addr  = ia;
    dm_req   = do_dm;
    dm_we    = dwe;
    dm_addr  = da;
    dm_wdata = dwd;
    for (int e = 0; e <= last_e; e++) begin
      tick();
      e_en     = (do_dm && e == g_dm) || (do_if && e == g_if);
      e_ack_if = do_if && (e == a_if);
      e_ack_dm = do_dm && (e == a_dm);
      e_busy   = (do_dm && e >= g_dm && e <= a_dm) || (do_if && e >= g_if && e <= a_if);
      chk("mem_en", mem_en, e_en);
      chk("busy", busy, e_busy);
      if (e_en && do_dm && e == g_dm) begin
        chk("dm_mem_addr", mem_addr, al(da));
        chk("dm_mem_we", mem_we, dwe);
        if (dwe) chk("dm_mem_wdata", mem_wdata, dwd);
      end else if (e_en) begin
        chk("if_mem_addr", mem_addr, al(ia));
        chk("if_mem_we", mem_we, 1'b0);
      end else begin
        chk("mem_we_idle", mem_we, 1'b0);
      end
      chk("if_ack", if_ack, e_ack_if);
      chk("dm_ack", dm_ack, e_ack_dm);
      chk("stall_if", stall_if, do_if && (e < a_if));
      chk("stall_mem", stall_mem, do_dm && (e < a_dm));
      if (e_ack_if) begin
        m_if_rdata = exp_if;
        chk("if_rdata", if_rdata, exp_if);
        if_req = 1'b0;
      end
      if (e_ack_dm) begin
        m_dm_rdata = exp_dm;
        chk("dm_rdata", dm_rdata, exp_dm);
        dm_req = 1'b0;
      end
      if (e == 0 && (do_if ^ do_dm)) begin
        if_addr  = {$urandom, $urandom};
        dm_addr  = {$urandom, $urandom};
        dm_wdata = {$urandom, $urandom};
        dm_we    = ~dm_we;
      end
    end
    chk("if_rdata_hold", if_rdata, m_if_rdata);
    chk("dm_rdata_hold", dm_rdata, m_dm_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          kind;
    int          n_cycles;
    bit          got_dm [$];
    int          got_e [$];
    bit          exp_dm_q [$];
    logic [63:0] ia, da, w;

    // Reset held low with random requests: everything stays cleared.
    repeat (6) begin
      tick();
      if_req   = 1'($urandom_range(0, 1));
      dm_req   = 1'($urandom_range(0, 1));
      dm_we    = 1'($urandom_range(0, 1));
      if_addr  = {$urandom, $urandom};
      dm_addr  = {$urandom, $urandom};
      dm_wdata = {$urandom, $urandom};
      #2;
      chk("rst_mem_en", mem_en, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, 64'h0);
      chk("rst_mem_wdata", mem_wdata, 64'h0);
      chk("rst_if_ack", if_ack, 1'b0);
      chk("rst_dm_ack", dm_ack, 1'b0);
      chk("rst_if_rdata", if_rdata, 64'h0);
      chk("rst_dm_rdata", dm_rdata, 64'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_stall_if", stall_if, if_req);
      chk("rst_stall_mem", stall_mem, dm_req);
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    tick();
    rst = 1'b1;
    repeat (5) begin
      tick();
      chk("idle_if_ack", if_ack, 1'b0);
      chk("idle_dm_ack", dm_ack, 1'b0);
      chk("idle_busy", busy, 1'b0);
    end

    // Contention right after reset: DM wins in both arbitration modes.
    txn(1'b1, 64'h300, 1'b1, 1'b0, 64'h200, 64'h0);

    // IF read of the upper instruction word.
    dev_mem[64'h100] = 64'hAAAABBBB11112222;
    ref_mem[64'h100] = 64'hAAAABBBB11112222;
    txn(1'b1, 64'h104, 1'b0, 1'b0, 64'h0, 64'h0);
    chk("if_read_word", if_rdata, 64'hAAAABBBB);

    // DM write to an unaligned address, then read it back.
    txn(1'b0, 64'h0, 1'b1, 1'b1, 64'h20B, 64'h0123456789ABCDEF);
    txn(1'b0, 64'h0, 1'b1, 1'b0, 64'h208, 64'h0);
    chk("dm_readback", dm_rdata, 64'h0123456789ABCDEF);

    // Both requests held through four back-to-back transactions.
    ia = 64'h140;
    da = 64'h1C0;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
      exp_dm_q.push_back(!last_dm);
      last_dm = !last_dm;
`else
      exp_dm_q.push_back(1'b1);
      last_dm = 1'b1;
`endif
      if (exp_dm_q[k]) m_dm_rdata = ref_rd(al(da));
      else begin
        w = ref_rd(al(ia));
        m_if_rdata = ia[2] ? w[63:32] : w[31:0];
      end
    end
    if_req  = 1'b1;
    if_addr = ia;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = da;
    n_cycles = 4 * (L + 3);
    for (int e = 0; e < n_cycles; e++) begin
      tick();
      if (dm_ack) begin got_dm.push_back(1'b1); got_e.push_back(e); end
      if (if_ack) begin got_dm.push_back(1'b0); got_e.push_back(e); end
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    chk("held_count", 64'(got_dm.size()), 64'd4);
    for (int k = 0; k < 4 && k < got_dm.size(); k++) begin
      chk("held_order", got_dm[k], exp_dm_q[k]);
      chk("held_ack_time", 64'(got_e[k]), 64'(k * (L + 3) + L + 1));
    end
    tick();
    chk("held_end_busy", busy, 1'b0);
    chk("held_if_rdata", if_rdata, m_if_rdata);
    chk("held_dm_rdata", dm_rdata, m_dm_rdata);

    // Reset asserted while the access sits in WAIT.
    if_req  = 1'b1;
    if_addr = 64'h0AC;
    tick();
    tick();
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("mid_rst_mem_en", mem_en, 1'b0);
    chk("mid_rst_if_ack", if_ack, 1'b0);
    chk("mid_rst_dm_ack", dm_ack, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_if_rdata", if_rdata, 64'h0);
    m_if_rdata = '0;
    m_dm_rdata = '0;
    last_dm    = 1'b0;
    repeat (2) begin
      tick();
      chk("in_rst_if_ack", if_ack, 1'b0);
    end
    rst = 1'b1;
    txn(1'b1, 64'h0AC, 1'b0, 1'b0, 64'h0, 64'h0);

    // Randomized mix of single and contending requests.
    repeat (24) begin
      kind = $urandom_range(0, 2);
      txn(kind != 1, 64'($urandom_range(0, 511)), kind != 0, 1'($urandom_range(0, 1)),
          64'($urandom_range(0, 511)), {$urandom, $urandom});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
